// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//   Result FIFO placed after the combinational ALU shift unit. Each accepted
//   result is stored with its zero flag and op tag. The head entry is offered to
//   the writeback consumer through a valid/ready handshake. The producer cannot
//   stall, so pushes refused while full are counted in a saturating drop counter.
//   A sticky zero flag records that any accepted result was zero.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready producer handshake; in_ready depends only on registered count
//   in_result/zero/tag producer payload
//   out_valid/ready   consumer handshake; out_valid = (count != 0)
//   out_result/zero/tag head payload, forced to 0 while empty
//   count             occupancy 0..DEPTH
//   zero_sticky       set by an accepted push with in_zero; sticky_clr clears it
//   drop_cnt          saturating count of refused pushes
module alu_result_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_result,
  input  logic                      in_zero,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_result,
  output logic                      out_zero,
  output logic [TAG_W-1:0]          out_tag,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      zero_sticky,
  input  logic                      sticky_clr,
  output logic [7:0]                drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic signed [DATA_W-1:0] mem_result [DEPTH];
  logic                     mem_zero   [DEPTH];
  logic [TAG_W-1:0]         mem_tag    [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;

  // Handshake decode from registered occupancy only (no ready-through-pop)
  always_comb begin
    in_ready  = (count != CW'(DEPTH));
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    drop      = in_valid && !in_ready;
  end

  // Storage write; contents need no reset because reads are gated by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= in_result;
      mem_zero[wr_ptr]   <= in_zero;
      mem_tag[wr_ptr]    <= in_tag;
    end
  end

  // Control state; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      zero_sticky <= 1'b0;
      drop_cnt    <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (push && in_zero)   zero_sticky <= 1'b1;
      else if (sticky_clr)   zero_sticky <= 1'b0;
      if (drop) drop_cnt <= sat_inc8(drop_cnt);
    end
  end

  // Head presentation, forced to zero while empty
  always_comb begin
    out_result = '0;
    out_zero   = 1'b0;
    out_tag    = '0;
    if (out_valid) begin
      out_result = mem_result[rd_ptr];
      out_zero   = mem_zero[rd_ptr];
      out_tag    = mem_tag[rd_ptr];
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer
//   Directed bench for alu_result_buffer: table of single-cycle vectors plus
//   hand-written sequences for streaming, drop saturation and async reset.
module tb_alu_result_buffer;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_result;
  logic               in_zero;
  logic [3:0]         in_tag;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_result;
  logic               out_zero;
  logic [3:0]         out_tag;
  logic [2:0]         count;
  logic               zero_sticky;
  logic               sticky_clr;
  logic [7:0]         drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_result_buffer #(.DATA_W(32), .DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_tag(out_tag),
    .count(count), .zero_sticky(zero_sticky), .sticky_clr(sticky_clr),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic        iv;
    logic [31:0] ires;
    logic        iz;
    logic [3:0]  itag;
    logic        ord;
    logic        clr;
    logic        ev;
    logic [31:0] eres;
    logic        ez;
    logic [3:0]  etag;
    logic [2:0]  ecnt;
    logic        erdy;
    logic        estk;
    logic [7:0]  edrop;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] eres,
                         input logic ez, input logic [3:0] etag, input logic [2:0] ecnt,
                         input logic erdy, input logic estk, input logic [7:0] edrop);
    chk({tag, ".out_valid"},   32'(out_valid),   32'(ev));
    chk({tag, ".out_result"},  out_result,       eres);
    chk({tag, ".out_zero"},    32'(out_zero),    32'(ez));
    chk({tag, ".out_tag"},     32'(out_tag),     32'(etag));
    chk({tag, ".count"},       32'(count),       32'(ecnt));
    chk({tag, ".in_ready"},    32'(in_ready),    32'(erdy));
    chk({tag, ".zero_sticky"}, 32'(zero_sticky), 32'(estk));
    chk({tag, ".drop_cnt"},    32'(drop_cnt),    32'(edrop));
  endtask

  task automatic drive(input logic iv, input logic [31:0] res, input logic z,
                       input logic [3:0] tg, input logic ord, input logic clr);
    in_valid   = iv;
    in_result  = res;
    in_zero    = z;
    in_tag     = tg;
    out_ready  = ord;
    sticky_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // iv ires iz itag ord clr | ev eres ez etag ecnt erdy estk edrop
    vecs[0]  = '{1'b1, 32'hFFFF_FFF0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 4'd1, 3'd1, 1'b1, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 32'd2, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 4'd1, 3'd2, 1'b1, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 32'd3, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 4'd1, 3'd3, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 32'd4, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 4'd1, 3'd4, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 32'd5, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 4'd1, 3'd4, 1'b0, 1'b0, 8'd1};
    // full + pop: push still refused, zero flag of the dropped push ignored
    vecs[5]  = '{1'b1, 32'd6, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 32'd2, 1'b0, 4'd2, 3'd3, 1'b1, 1'b0, 8'd2};
    vecs[6]  = '{1'b0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 32'd3, 1'b0, 4'd3, 3'd2, 1'b1, 1'b0, 8'd2};
    vecs[7]  = '{1'b0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 32'd4, 1'b0, 4'd4, 3'd1, 1'b1, 1'b0, 8'd2};
    vecs[8]  = '{1'b0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 8'd2};
    vecs[9]  = '{1'b0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 8'd2};
    vecs[10] = '{1'b1, 32'd0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 4'd7, 3'd1, 1'b1, 1'b1, 8'd2};
    vecs[11] = '{1'b1, 32'd5, 1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 32'd5, 1'b1, 4'd8, 3'd1, 1'b1, 1'b1, 8'd2};
    vecs[12] = '{1'b0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 8'd2};
    vecs[13] = '{1'b1, 32'd9, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 32'd9, 1'b0, 4'd9, 3'd1, 1'b1, 1'b0, 8'd2};
    vecs[14] = '{1'b0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 8'd2};

    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk_all("reset", 1'b0, 32'd0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 8'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].iv, vecs[i].ires, vecs[i].iz, vecs[i].itag, vecs[i].ord, vecs[i].clr);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eres, vecs[i].ez, vecs[i].etag,
              vecs[i].ecnt, vecs[i].erdy, vecs[i].estk, vecs[i].edrop);
    end

    // Streaming: push and pop every cycle, occupancy settles at 1
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i), 1'b0, 4'(i), 1'b1, 1'b0);
      tick();
      chk($sformatf("stream%0d.count", i), 32'(count), 32'd1);
      chk($sformatf("stream%0d.result", i), out_result, 32'(i));
      chk($sformatf("stream%0d.drop", i), 32'(drop_cnt), 32'd2);
    end
    drive(1'b0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    chk("stream_end.valid", 32'(out_valid), 32'd0);

    // Saturation: fill, then 300 refused pushes carrying in_zero=1
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(100 + i), 1'b0, 4'(i), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 32'hDEAD_0000 + 32'(i), 1'b1, 4'hF, 1'b0, 1'b0);
      tick();
    end
    chk("sat.drop", 32'(drop_cnt), 32'd255);
    chk("sat.count", 32'(count), 32'd4);
    chk("sat.sticky", 32'(zero_sticky), 32'd0);
    chk("sat.head", out_result, 32'd100);
    chk("sat.tag", 32'(out_tag), 32'd0);

    // Async reset with three entries held
    drive(1'b0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    chk("pre_rst.count", 32'(count), 32'd3);
    chk("pre_rst.head", out_result, 32'd101);
    drive(1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 32'd0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 8'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h0000_ABCD, 1'b0, 4'd5, 1'b0, 1'b0);
    tick();
    chk_all("post_rst", 1'b1, 32'h0000_ABCD, 1'b0, 4'd5, 3'd1, 1'b1, 1'b0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
